spi_master_burst: RTL
=====================

// Module: spi_master_burst
// PURPOSE
//  Parametrised SPI master: configurable word width, runtime CPOL/CPHA mode, runtime clock divider,
//  MSB/LSB-first, NUM_CS active-low chip selects, multi-word bursts with CS held between words.
//  Sits between a valid/ready command source (CPU regs or DMA) and off-chip SPI slaves.
// PARAMETERS
//  DATA_W  8  bits per SPI word (2..32)
//  NUM_CS  4  number of chip-select lines (1..16)
//  DIV_W   8  width of cfg_div
// PORTS
//  clk            in   1              system clock
//  rst_n          in   1              reset, asynchronous, active-low
//  cfg_cpol       in   1              SCLK idle level
//  cfg_cpha       in   1              0: sample leading edge; 1: sample trailing edge
//  cfg_lsb_first  in   1              1: shift LSB first
//  cfg_div        in   DIV_W          SCLK half-period = cfg_div+1 clk cycles
//  tx_valid       in   1              command word valid
//  tx_ready       out  1              command word accepted when tx_valid&tx_ready
//  tx_data        in   DATA_W         word to transmit
//  tx_cs          in   clog2(NUM_CS)  target slave index (sampled on first word of burst only)
//  tx_last        in   1              1: deassert CS after this word
//  rx_valid       out  1              1-cycle pulse, rx_data valid; no backpressure
//  rx_data        out  DATA_W         received word
//  busy           out  1              high from burst accept until return to IDLE
//  SPI_MISO       in   1              serial data from slave
//  SPI_MOSI       out  1              serial data to slave
//  SPI_CLK        out  1              SPI clock
//  SPI_EN         out  NUM_CS         active-low chip selects (one-hot-low)
// BEHAVIOUR
//  Reset (async): state=IDLE, SPI_EN='1, SPI_CLK=0, SPI_MOSI=0, rx_data=0, rx_valid=0, busy=0.
//   Mid-transfer reset aborts immediately; no rx_valid for the partial word.
//  cfg_* latched on the burst's first accept; changes mid-burst ignored.
//  In IDLE, SPI_CLK tracks cfg_cpol (registered, 1-cycle delay).
//  States: IDLE -> SETUP -> SHIFT -> (HOLD -> SHIFT)* -> DONE -> IDLE.
//   IDLE : tx_ready=1. On accept: latch data/cs/last/cfg, assert SPI_EN[tx_cs]. -> SETUP.
//   SETUP: one half-period, SCLK at CPOL. CPHA=0: first bit on MOSI at entry. -> SHIFT.
//   SHIFT: SCLK toggles every cfg_div+1 clk; 2*DATA_W edges per word.
//          CPHA=0: sample MISO on odd edges (1,3,..); drive next bit on even edges (not after last).
//          CPHA=1: drive bit on odd edges; sample MISO on even edges.
//          After edge 2*DATA_W: rx_data updated and rx_valid pulses next cycle;
//          last=1 -> DONE, else -> HOLD.
//   HOLD : CS held low, SCLK at CPOL, tx_ready=1. Accept -> latch data/last only,
//          one half-period setup (as SETUP) -> SHIFT. Waits indefinitely without tx_valid.
//   DONE : one half-period with CS low, then SPI_EN='1; -> IDLE.
//  tx_ready=0 in SETUP/SHIFT/DONE. Bit order: MSB first unless lsb_first; rx assembled in same order.
//  cfg_div=0: SCLK = clk/2. Divider counter is DIV_W bits, reloads on each edge, no wrap issue.
//  tx_cs >= NUM_CS: transfer runs normally, all SPI_EN stay high, rx_valid still pulses.
//  Simultaneous rx_valid and tx accept in HOLD is legal.
// TESTING
//  Mode0, div=0, MISO looped to MOSI, send 0xA5 last=1 -> rx_data=0xA5, 8 SCLK pulses, SCLK period 2 clk.
//  Mode3, div=3, slave returns 0x3C -> SCLK idles 1, period 8 clk, rx_data=0x3C, MOSI changes on falling edges.
//  Burst 0x11,0x22,0x33 (last on 3rd), tx_cs=2 -> SPI_EN=4'b1011 continuously, three rx_valid pulses.
//  lsb_first=1, send 0x01, mode1 -> first MOSI bit=1, remaining seven bits 0.
//  HOLD stall: omit tx_valid for 50 cycles mid-burst -> CS stays low, SCLK static at CPOL, tx_ready=1.
//  Assert rst_n=0 at bit 4 -> SPI_EN='1, SPI_CLK=0, busy=0 same cycle; no rx_valid.

Source files
------------

// File: rtl/spi_master_burst.sv
// spi_master_burst: SPI master with runtime CPOL/CPHA, clock divider,
// MSB/LSB-first shifting and multi-word bursts that keep CS asserted.
module spi_master_burst #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CSW-1:0]    tx_cs,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    input  logic              SPI_MISO,
    output logic              SPI_MOSI,
    output logic              SPI_CLK,
    output logic [NUM_CS-1:0] SPI_EN
);
    localparam int            EW        = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    cnt_q, div_q;
    logic [EW-1:0]       edge_q, edge_d;
    logic [DATA_W-1:0]   data_q, rx_q, rx_d, rx_data_q;
    logic                cpol_q, cpha_q, lsb_q, last_q;
    logic                sclk_q, mosi_q, rx_valid_q;
    logic [NUM_CS-1:0]   en_q;

    // Bit k of the word in transmission order.
    function automatic logic pick_bit(input logic [DATA_W-1:0] d, input logic lsb,
                                      input logic [EW-1:0] k);
        logic b;
        b = 1'b0;
        for (int i = 0; i < DATA_W; i++)
            if (EW'(i) == k) b = lsb ? d[i] : d[DATA_W-1-i];
        return b;
    endfunction

    // One-hot-low select; an out-of-range index leaves every line high.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] idx);
        logic [NUM_CS-1:0] en;
        en = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(idx) == i) en[i] = 1'b0;
        return en;
    endfunction

    // Next SCLK edge number and receive shift value including the current MISO bit.
    always_comb begin
        edge_d = edge_q + 1'b1;
        rx_d   = cfg_lsb_first_unused_guard(rx_q);
    end

    function automatic logic [DATA_W-1:0] cfg_lsb_first_unused_guard(input logic [DATA_W-1:0] r);
        return lsb_q ? {SPI_MISO, r[DATA_W-1:1]} : {r[DATA_W-2:0], SPI_MISO};
    endfunction

    // Transfer FSM; every SPI pin and status bit comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            data_q     <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            last_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            en_q       <= '1;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= cfg_cpol;
                    if (tx_valid) begin
                        data_q  <= tx_data;
                        last_q  <= tx_last;
                        cpol_q  <= cfg_cpol;
                        cpha_q  <= cfg_cpha;
                        lsb_q   <= cfg_lsb_first;
                        div_q   <= cfg_div;
                        cnt_q   <= cfg_div;
                        en_q    <= cs_decode(tx_cs);
                        if (!cfg_cpha) mosi_q <= pick_bit(tx_data, cfg_lsb_first, '0);
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    sclk_q <= cpol_q;
                    if (cnt_q == '0) begin
                        cnt_q   <= div_q;
                        edge_q  <= '0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        cnt_q  <= div_q;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_d;
                        // CPHA=0 samples on odd edges, CPHA=1 on even edges; the other edge drives.
                        if (edge_d[0] != cpha_q) rx_q <= rx_d;
                        else if (edge_d != LAST_EDGE) mosi_q <= pick_bit(data_q, lsb_q, edge_d >> 1);
                        if (edge_d == LAST_EDGE) begin
                            rx_data_q  <= cpha_q ? rx_d : rx_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= last_q ? DONE : HOLD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    sclk_q <= cpol_q;
                    if (tx_valid) begin
                        data_q  <= tx_data;
                        last_q  <= tx_last;
                        cnt_q   <= div_q;
                        if (!cpha_q) mosi_q <= pick_bit(tx_data, lsb_q, '0);
                        state_q <= SETUP;
                    end
                end
                DONE: begin
                    sclk_q <= cpol_q;
                    if (cnt_q == '0) begin
                        en_q    <= '1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready = (state_q == IDLE) || (state_q == HOLD);
    assign busy     = (state_q != IDLE);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign SPI_MOSI = mosi_q;
    assign SPI_CLK  = sclk_q;
    assign SPI_EN   = en_q;

endmodule
